// File: rtl/fpga_clk_mon_pkg.sv
// Shared definitions for the fpga_clk_mon clock-health monitor:
// FSM state encodings, status counter widths and the reset-request stretch length.
`timescale 1ns/1ps
package fpga_clk_mon_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_ARM  = 2'd1;
    localparam fsm_state_t ST_MEAS = 2'd2;
    localparam fsm_state_t ST_EVAL = 2'd3;

    // Length of the reset request pulse, in fpga_clk_out cycles
    localparam int RSTREQ_LEN = 16;

    // Width of the bad-window total counter and of the good/bad run counters
    localparam int FAIL_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (v == {FAIL_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fpga_ref_tgl_gen.sv
// Reference toggle generator: flips ref_tgl once every REF_DIV fpga_clk_in cycles.
// It runs in the raw reference clock domain; the monitor synchronises ref_tgl.
`timescale 1ns/1ps
module fpga_ref_tgl_gen #(
    parameter int REF_DIV = 1000
) (
    input  logic fpga_clk_in,
    input  logic fpga_rst_in,
    output logic ref_tgl
);

    localparam int DIV_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(REF_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic             ref_tgl_reg;

    // Down-counter reloads on zero and toggles the reference level
    always_ff @(posedge fpga_clk_in or negedge fpga_rst_in) begin
        if (!fpga_rst_in) begin
            div_cnt_reg <= DIV_RELOAD;
            ref_tgl_reg <= 1'b0;
        end else if (div_cnt_reg == '0) begin
            div_cnt_reg <= DIV_RELOAD;
            ref_tgl_reg <= ~ref_tgl_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
        end
    end

    assign ref_tgl = ref_tgl_reg;

endmodule

// File: rtl/fpga_clk_mon.sv
// Clock-health monitor: counts fpga_clk_out cycles per reference window derived
// from fpga_clk_in, classifies each window against EXP_CNT +/- TOL, and reports
// a qualified clk_ok, a sticky clk_fail and a saturating bad-window count.
// Optional: define FPGA_CLK_MON_RSTREQ_EN to build the 16-cycle reset request
// stretcher; otherwise rst_req is tied low.
`timescale 1ns/1ps
module fpga_clk_mon
    import fpga_clk_mon_pkg::*;
#(
    parameter int REF_DIV    = 1000,
    parameter int EXP_CNT    = 400,
    parameter int TOL        = 4,
    parameter int CNT_W      = 16,
    parameter int GOOD_LIMIT = 2,
    parameter int BAD_LIMIT  = 2
) (
    input  logic                  fpga_clk_out,
    input  logic                  fpga_rst_in,
    input  logic                  fpga_clk_in,
    input  logic                  mon_en,
    output logic [CNT_W-1:0]      meas_cnt,
    output logic                  meas_valid,
    output logic                  clk_ok,
    output logic                  clk_fail,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic                  rst_req
);

    localparam logic [CNT_W-1:0]        CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic signed [CNT_W:0]   LO_S       = (CNT_W+1)'(EXP_CNT - TOL);
    localparam logic signed [CNT_W:0]   HI_S       = (CNT_W+1)'(EXP_CNT + TOL);
    localparam logic [FAIL_CNT_W-1:0]   GOOD_LIM_V = FAIL_CNT_W'(GOOD_LIMIT);
    localparam logic [FAIL_CNT_W-1:0]   BAD_LIM_V  = FAIL_CNT_W'(BAD_LIMIT);

    logic ref_tgl;
    logic ref_sync1_reg, ref_sync2_reg, ref_sync3_reg;
    logic ref_edge;

    fsm_state_t             state_reg,      state_next;
    logic [CNT_W-1:0]       win_cnt_reg,    win_cnt_next;
    logic [CNT_W-1:0]       cap_cnt_reg,    cap_cnt_next;
    logic                   timeout_reg,    timeout_next;
    logic [CNT_W-1:0]       meas_cnt_reg,   meas_cnt_next;
    logic                   meas_valid_reg, meas_valid_next;
    logic [FAIL_CNT_W-1:0]  good_run_reg,   good_run_next;
    logic [FAIL_CNT_W-1:0]  bad_run_reg,    bad_run_next;
    logic [FAIL_CNT_W-1:0]  fail_cnt_reg,   fail_cnt_next;
    logic                   clk_ok_reg,     clk_ok_next;
    logic                   clk_fail_reg,   clk_fail_next;

    logic [CNT_W-1:0]       win_cnt_inc;
    logic [FAIL_CNT_W-1:0]  good_run_inc, bad_run_inc;
    logic signed [CNT_W:0]  cap_s;
    logic                   win_good;

    fpga_ref_tgl_gen #(
        .REF_DIV (REF_DIV)
    ) u_ref_tgl_gen (
        .fpga_clk_in (fpga_clk_in),
        .fpga_rst_in (fpga_rst_in),
        .ref_tgl     (ref_tgl)
    );

    // Two-flop synchroniser for ref_tgl plus one flop for edge detection
    always_ff @(posedge fpga_clk_out or negedge fpga_rst_in) begin
        if (!fpga_rst_in) begin
            ref_sync1_reg <= 1'b0;
            ref_sync2_reg <= 1'b0;
            ref_sync3_reg <= 1'b0;
        end else begin
            ref_sync1_reg <= ref_tgl;
            ref_sync2_reg <= ref_sync1_reg;
            ref_sync3_reg <= ref_sync2_reg;
        end
    end

    assign ref_edge    = ref_sync2_reg ^ ref_sync3_reg;
    assign win_cnt_inc = (win_cnt_reg == CNT_MAX) ? CNT_MAX : win_cnt_reg + 1'b1;
    assign cap_s       = $signed({1'b0, cap_cnt_reg});
    assign win_good    = !timeout_reg && (cap_s >= LO_S) && (cap_s <= HI_S);
    assign good_run_inc = sat_inc(good_run_reg);
    assign bad_run_inc  = sat_inc(bad_run_reg);

    // Next-state logic: window FSM, window counter and qualification status
    always_comb begin
        state_next      = state_reg;
        win_cnt_next    = win_cnt_reg;
        cap_cnt_next    = cap_cnt_reg;
        timeout_next    = timeout_reg;
        meas_cnt_next   = meas_cnt_reg;
        meas_valid_next = 1'b0;
        good_run_next   = good_run_reg;
        bad_run_next    = bad_run_reg;
        fail_cnt_next   = fail_cnt_reg;
        clk_ok_next     = clk_ok_reg;
        clk_fail_next   = clk_fail_reg;

        if (!mon_en) begin
            // Disable overrides everything, including a coincident ref_edge
            state_next    = ST_IDLE;
            timeout_next  = 1'b0;
            clk_ok_next   = 1'b0;
            clk_fail_next = 1'b0;
            good_run_next = '0;
            bad_run_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    // Only a full window is measured, so wait for a boundary
                    if (ref_edge) begin
                        win_cnt_next = CNT_ONE;
                        timeout_next = 1'b0;
                        state_next   = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (ref_edge) begin
                        cap_cnt_next = win_cnt_reg;
                        timeout_next = 1'b0;
                        win_cnt_next = CNT_ONE;
                        state_next   = ST_EVAL;
                    end else if (win_cnt_reg == CNT_MAX) begin
                        cap_cnt_next = CNT_MAX;
                        timeout_next = 1'b1;
                        state_next   = ST_EVAL;
                    end else begin
                        win_cnt_next = win_cnt_inc;
                    end
                end
                default: begin // ST_EVAL
                    meas_valid_next = 1'b1;
                    meas_cnt_next   = timeout_reg ? CNT_MAX : cap_cnt_reg;
                    // The EVAL cycle already belongs to the following window
                    win_cnt_next    = ref_edge ? CNT_ONE : win_cnt_inc;
                    if (win_good) begin
                        bad_run_next  = '0;
                        good_run_next = good_run_inc;
                        if (good_run_inc >= GOOD_LIM_V) begin
                            clk_ok_next = 1'b1;
                        end
                    end else begin
                        good_run_next = '0;
                        clk_ok_next   = 1'b0;
                        bad_run_next  = bad_run_inc;
                        fail_cnt_next = sat_inc(fail_cnt_reg);
                        if (bad_run_inc >= BAD_LIM_V) begin
                            clk_fail_next = 1'b1;
                        end
                    end
                    // After a timeout, resynchronise unless an edge arrives right now
                    state_next = (timeout_reg && !ref_edge) ? ST_ARM : ST_MEAS;
                end
            endcase
        end
    end

    // State and status registers
    always_ff @(posedge fpga_clk_out or negedge fpga_rst_in) begin
        if (!fpga_rst_in) begin
            state_reg      <= ST_IDLE;
            win_cnt_reg    <= '0;
            cap_cnt_reg    <= '0;
            timeout_reg    <= 1'b0;
            meas_cnt_reg   <= '0;
            meas_valid_reg <= 1'b0;
            good_run_reg   <= '0;
            bad_run_reg    <= '0;
            fail_cnt_reg   <= '0;
            clk_ok_reg     <= 1'b0;
            clk_fail_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            win_cnt_reg    <= win_cnt_next;
            cap_cnt_reg    <= cap_cnt_next;
            timeout_reg    <= timeout_next;
            meas_cnt_reg   <= meas_cnt_next;
            meas_valid_reg <= meas_valid_next;
            good_run_reg   <= good_run_next;
            bad_run_reg    <= bad_run_next;
            fail_cnt_reg   <= fail_cnt_next;
            clk_ok_reg     <= clk_ok_next;
            clk_fail_reg   <= clk_fail_next;
        end
    end

    assign meas_cnt   = meas_cnt_reg;
    assign meas_valid = meas_valid_reg;
    assign clk_ok     = clk_ok_reg;
    assign clk_fail   = clk_fail_reg;
    assign fail_cnt   = fail_cnt_reg;

`ifdef FPGA_CLK_MON_RSTREQ_EN
    localparam int RSTREQ_CNT_W = $clog2(RSTREQ_LEN);
    localparam logic [RSTREQ_CNT_W-1:0] RSTREQ_RELOAD = RSTREQ_CNT_W'(RSTREQ_LEN - 1);

    logic [RSTREQ_CNT_W-1:0] rstreq_cnt_reg;
    logic                    rst_req_reg;
    logic                    clk_fail_d_reg;

    // Stretch each clk_fail rising edge into a fixed-length reset request
    always_ff @(posedge fpga_clk_out or negedge fpga_rst_in) begin
        if (!fpga_rst_in) begin
            rstreq_cnt_reg <= '0;
            rst_req_reg    <= 1'b0;
            clk_fail_d_reg <= 1'b0;
        end else begin
            clk_fail_d_reg <= clk_fail_reg;
            if (clk_fail_reg && !clk_fail_d_reg) begin
                rstreq_cnt_reg <= RSTREQ_RELOAD;
                rst_req_reg    <= 1'b1;
            end else if (rstreq_cnt_reg != '0) begin
                rstreq_cnt_reg <= rstreq_cnt_reg - 1'b1;
            end else begin
                rst_req_reg    <= 1'b0;
            end
        end
    end

    assign rst_req = rst_req_reg;
`else
    assign rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_clk_mon.sv
// Self-checking bench for fpga_clk_mon: table of clock-period vectors with
// hand-computed count ranges and status, plus sequences for mon_en abort,
// reference-clock loss (timeout) and asynchronous reset.
// Honours FPGA_CLK_MON_RSTREQ_EN when checking rst_req.
`timescale 1ns/1ps
module tb_fpga_clk_mon;

    localparam int CNT_W = 10;

    logic             fpga_clk_out;
    logic             fpga_rst_in;
    logic             fpga_clk_in;
    logic             mon_en;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             clk_ok;
    logic             clk_fail;
    logic [7:0]       fail_cnt;
    logic             rst_req;

    int  out_period_ps = 50000;
    bit  ref_run       = 1'b1;
    int  pass_cnt      = 0;
    int  total_cnt     = 0;
    int  rr_cycles     = 0;
    int  rr_rises      = 0;
    bit  rr_prev       = 1'b0;

    fpga_clk_mon #(
        .REF_DIV    (1000),
        .EXP_CNT    (400),
        .TOL        (4),
        .CNT_W      (CNT_W),
        .GOOD_LIMIT (2),
        .BAD_LIMIT  (2)
    ) dut (
        .fpga_clk_out (fpga_clk_out),
        .fpga_rst_in  (fpga_rst_in),
        .fpga_clk_in  (fpga_clk_in),
        .mon_en       (mon_en),
        .meas_cnt     (meas_cnt),
        .meas_valid   (meas_valid),
        .clk_ok       (clk_ok),
        .clk_fail     (clk_fail),
        .fail_cnt     (fail_cnt),
        .rst_req      (rst_req)
    );

    // Monitored clock with a run-time adjustable period (picoseconds)
    initial begin
        fpga_clk_out = 1'b0;
        forever begin
            #(real'(out_period_ps / 2) / 1000.0);
            fpga_clk_out = 1'b1;
            #(real'(out_period_ps - out_period_ps / 2) / 1000.0);
            fpga_clk_out = 1'b0;
        end
    end

    // 50 MHz reference clock that can be frozen
    initial begin
        fpga_clk_in = 1'b0;
        #3.0;
        forever begin
            #10.0;
            if (ref_run) fpga_clk_in = ~fpga_clk_in;
        end
    end

    // Count rst_req high cycles and rising edges
    always @(negedge fpga_clk_out) begin
        if (rst_req) rr_cycles++;
        if (rst_req && !rr_prev) rr_rises++;
        rr_prev = rst_req;
    end

    typedef struct {
        int   period_ps;
        int   nwin;
        int   cnt_lo;
        int   cnt_hi;
        logic exp_ok;
        logic exp_fail;
        int   exp_fcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic wait_valid(input string name, input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge fpga_clk_out);
            if (meas_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL %s: got no meas_valid, expected one within %0d cycles", name, limit);
        end else begin
            $display("win %s: meas_cnt=%0d clk_ok=%0b clk_fail=%0b fail_cnt=%0d",
                     name, meas_cnt, clk_ok, clk_fail, fail_cnt);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_cnt"},   int'(meas_cnt),   0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_clk_ok"},     int'(clk_ok),     0);
        check({tag, "_clk_fail"},   int'(clk_fail),   0);
        check({tag, "_fail_cnt"},   int'(fail_cnt),   0);
        check({tag, "_rst_req"},    int'(rst_req),    0);
    endtask

    initial begin
        bit got;
        int quiet_valids;

        //            period  nwin lo   hi   ok    fail  fcnt
        vecs[0] = '{50000, 1, 399, 401, 1'b0, 1'b0, 0}; // nominal, one window: not yet qualified
        vecs[1] = '{50000, 2, 399, 401, 1'b1, 1'b0, 0}; // nominal, qualified after 2nd window
        vecs[2] = '{40000, 1, 499, 501, 1'b0, 1'b0, 1}; // 25 MHz, one bad window
        vecs[3] = '{40000, 2, 499, 501, 1'b0, 1'b1, 3}; // 25 MHz, two bad -> clk_fail
        vecs[4] = '{49505, 2, 403, 404, 1'b1, 1'b0, 3}; // upper edge, good
        vecs[5] = '{49380, 1, 405, 406, 1'b0, 1'b0, 4}; // just above upper edge, bad
        vecs[6] = '{50500, 2, 396, 397, 1'b1, 1'b0, 4}; // lower edge, good
        vecs[7] = '{50640, 1, 394, 395, 1'b0, 1'b0, 5}; // just below lower edge, bad
        vecs[8] = '{50000, 3, 399, 401, 1'b1, 1'b0, 5}; // back to nominal

        fpga_rst_in = 1'b0;
        mon_en      = 1'b0;
        repeat (3) @(negedge fpga_clk_out);
        check_all_zero("reset");
        fpga_rst_in = 1'b1;
        repeat (2) @(negedge fpga_clk_out);

        // Table-driven windows; mon_en is cycled before each vector to clear runs
        for (int v = 0; v < 9; v++) begin
            mon_en = 1'b0;
            repeat (3) @(negedge fpga_clk_out);
            out_period_ps = vecs[v].period_ps;
            repeat (2) @(negedge fpga_clk_out);
            mon_en = 1'b1;
            for (int w = 0; w < vecs[v].nwin; w++) begin
                wait_valid($sformatf("v%0d_w%0d", v, w), 2500, got);
                if (got) check_range($sformatf("v%0d_w%0d_cnt", v, w), int'(meas_cnt),
                                     vecs[v].cnt_lo, vecs[v].cnt_hi);
            end
            check($sformatf("v%0d_clk_ok", v),   int'(clk_ok),   int'(vecs[v].exp_ok));
            check($sformatf("v%0d_clk_fail", v), int'(clk_fail), int'(vecs[v].exp_fail));
            check($sformatf("v%0d_fail_cnt", v), int'(fail_cnt), vecs[v].exp_fcnt);
        end

        // mon_en dropped mid-window: no valid for the aborted window, status cleared
        repeat (100) @(negedge fpga_clk_out);
        mon_en = 1'b0;
        quiet_valids = 0;
        repeat (3) begin
            @(negedge fpga_clk_out);
            if (meas_valid) quiet_valids++;
        end
        check("abort_clk_ok",   int'(clk_ok),   0);
        check("abort_clk_fail", int'(clk_fail), 0);
        check("abort_fail_cnt", int'(fail_cnt), 5);
        check_range("abort_meas_cnt_kept", int'(meas_cnt), 399, 401);
        mon_en = 1'b1;
        repeat (600) begin
            @(negedge fpga_clk_out);
            if (meas_valid) quiet_valids++;
        end
        check("abort_no_valid", quiet_valids, 0);
        wait_valid("rearm_w0", 400, got);
        if (got) check_range("rearm_w0_cnt", int'(meas_cnt), 399, 401);
        check("rearm_w0_clk_ok", int'(clk_ok), 0);
        wait_valid("rearm_w1", 600, got);
        check("rearm_w1_clk_ok", int'(clk_ok), 1);

        // Reference clock lost: counter saturates, timeout is a bad window
        ref_run = 1'b0;
        wait_valid("timeout0", 1500, got);
        check("timeout0_cnt",      int'(meas_cnt), 1023);
        check("timeout0_clk_ok",   int'(clk_ok),   0);
        check("timeout0_clk_fail", int'(clk_fail), 0);
        check("timeout0_fail_cnt", int'(fail_cnt), 6);
        // Let exactly one reference toggle through to re-arm, then freeze again
        ref_run = 1'b1;
        #21000.0;
        ref_run = 1'b0;
        wait_valid("timeout1", 1500, got);
        check("timeout1_cnt",      int'(meas_cnt), 1023);
        check("timeout1_clk_fail", int'(clk_fail), 1);
        check("timeout1_fail_cnt", int'(fail_cnt), 7);

        // Asynchronous reset mid-window
        ref_run = 1'b1;
        #2000.0;
        #7.3;
        fpga_rst_in = 1'b0;
        #1.0;
        check_all_zero("async_rst");
        #200.0;
        fpga_rst_in = 1'b1;
        wait_valid("post_rst_w0", 2500, got);
        if (got) check_range("post_rst_w0_cnt", int'(meas_cnt), 399, 401);
        check("post_rst_w0_clk_ok", int'(clk_ok), 0);
        wait_valid("post_rst_w1", 600, got);
        check("post_rst_w1_clk_ok",   int'(clk_ok),   1);
        check("post_rst_w1_clk_fail", int'(clk_fail), 0);
        check("post_rst_w1_fail_cnt", int'(fail_cnt), 0);

        // Reset request: one 16-cycle pulse per clk_fail rise (two rises above)
`ifdef FPGA_CLK_MON_RSTREQ_EN
        check("rst_req_cycles", rr_cycles, 32);
        check("rst_req_pulses", rr_rises,  2);
`else
        check("rst_req_cycles", rr_cycles, 0);
        check("rst_req_pulses", rr_rises,  0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
